// File: rtl/mult_div_unit_if.sv
// Operand/result bundle between the control datapath and mult_div_unit.
// MULTDIV_UNSIGNED_EN adds the is_unsigned select for multu/divu.
interface mult_div_unit_if #(
  parameter int WIDTH = 32
);

  logic             mult_start;
  logic             div_start;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
`ifdef MULTDIV_UNSIGNED_EN
  logic             is_unsigned;
`endif
  logic [WIDTH-1:0] hi_out;
  logic [WIDTH-1:0] lo_out;
  logic             busy;
  logic             done;
  logic             div_zero;

  modport master (
    output mult_start, div_start, a_in, b_in,
`ifdef MULTDIV_UNSIGNED_EN
    output is_unsigned,
`endif
    input  hi_out, lo_out, busy, done, div_zero
  );

  modport slave (
    input  mult_start, div_start, a_in, b_in,
`ifdef MULTDIV_UNSIGNED_EN
    input  is_unsigned,
`endif
    output hi_out, lo_out, busy, done, div_zero
  );

endinterface

// File: rtl/mult_div_unit.sv
// Multicycle radix-2 Booth multiplier / restoring divider producing HI/LO.
// Build option MULTDIV_UNSIGNED_EN enables bus.is_unsigned (multu/divu).
module mult_div_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input logic            clock,
  input logic            reset,
  mult_div_unit_if.slave bus
);

  localparam int AW = WIDTH + 2;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_MULT = 3'd1,
    S_DIV  = 3'd2,
    S_FIX  = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t           state_r, state_s;
  logic [CNT_W-1:0] cnt_r;
  logic [AW-1:0]    acc_r;      // Booth partial product / divide remainder
  logic [AW-1:0]    m_r;        // multiplicand or divisor magnitude
  logic [WIDTH-1:0] q_r;        // Booth multiplier / dividend-then-quotient
  logic             qm1_r;
  logic             corr_r;
  logic             neg_q_r;
  logic             neg_rem_r;
  logic [WIDTH-1:0] hi_r, lo_r;
  logic             busy_r, done_r, dz_r;

  logic             uns_s, a_neg_s, b_neg_s, b_zero_s, last_s;
  logic [AW-1:0]    a_ext_s, booth_sum_s, booth_acc_s, div_shift_s, div_trial_s;
  logic [WIDTH-1:0] booth_q_s, prod_hi_s;

  function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] v, input logic neg);
    return neg ? (~v + WIDTH'(1'b1)) : v;
  endfunction

`ifdef MULTDIV_UNSIGNED_EN
  assign uns_s = bus.is_unsigned;
`else
  assign uns_s = 1'b0;
`endif

  assign a_neg_s  = ~uns_s & bus.a_in[WIDTH-1];
  assign b_neg_s  = ~uns_s & bus.b_in[WIDTH-1];
  assign b_zero_s = (bus.b_in == {WIDTH{1'b0}});
  assign last_s   = (cnt_r == CNT_W'(WIDTH - 1));
  assign a_ext_s  = uns_s ? {2'b00, bus.a_in} : {{2{bus.a_in[WIDTH-1]}}, bus.a_in};

  // Single-iteration Booth and restoring-divide steps; unsigned multiply adds back the multiplier-MSB weight.
  always_comb begin
    booth_sum_s = acc_r;
    case ({q_r[0], qm1_r})
      2'b01:   booth_sum_s = acc_r + m_r;
      2'b10:   booth_sum_s = acc_r - m_r;
      default: booth_sum_s = acc_r;
    endcase
    booth_acc_s = {booth_sum_s[AW-1], booth_sum_s[AW-1:1]};
    booth_q_s   = {booth_sum_s[0], q_r[WIDTH-1:1]};
    if (corr_r) begin
      prod_hi_s = booth_acc_s[WIDTH-1:0] + m_r[WIDTH-1:0];
    end else begin
      prod_hi_s = booth_acc_s[WIDTH-1:0];
    end
    div_shift_s = {acc_r[AW-2:0], q_r[WIDTH-1]};
    div_trial_s = div_shift_s - m_r;
  end

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (bus.mult_start) begin
          state_s = S_MULT;
        end else if (bus.div_start) begin
          state_s = b_zero_s ? S_DONE : S_DIV;
        end else begin
          state_s = S_IDLE;
        end
      end
      S_MULT:  state_s = last_s ? S_DONE : S_MULT;
      S_DIV:   state_s = last_s ? S_FIX : S_DIV;
      S_FIX:   state_s = S_DONE;
      S_DONE:  state_s = S_IDLE;
      default: state_s = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Operand capture and iteration datapath.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt_r     <= {CNT_W{1'b0}};
      acc_r     <= {AW{1'b0}};
      m_r       <= {AW{1'b0}};
      q_r       <= {WIDTH{1'b0}};
      qm1_r     <= 1'b0;
      corr_r    <= 1'b0;
      neg_q_r   <= 1'b0;
      neg_rem_r <= 1'b0;
    end else begin
      case (state_r)
        S_IDLE: begin
          if (bus.mult_start) begin
            cnt_r  <= {CNT_W{1'b0}};
            acc_r  <= {AW{1'b0}};
            m_r    <= a_ext_s;
            q_r    <= bus.b_in;
            qm1_r  <= 1'b0;
            corr_r <= uns_s & bus.b_in[WIDTH-1];
          end else if (bus.div_start) begin
            cnt_r     <= {CNT_W{1'b0}};
            acc_r     <= {AW{1'b0}};
            m_r       <= {2'b00, cond_neg(bus.b_in, b_neg_s)};
            q_r       <= cond_neg(bus.a_in, a_neg_s);
            neg_q_r   <= a_neg_s ^ b_neg_s;
            neg_rem_r <= a_neg_s;
          end
        end
        S_MULT: begin
          acc_r <= booth_acc_s;
          q_r   <= booth_q_s;
          qm1_r <= q_r[0];
          cnt_r <= cnt_r + CNT_W'(1);
        end
        S_DIV: begin
          if (div_trial_s[AW-1]) begin
            acc_r <= div_shift_s;
            q_r   <= {q_r[WIDTH-2:0], 1'b0};
          end else begin
            acc_r <= div_trial_s;
            q_r   <= {q_r[WIDTH-2:0], 1'b1};
          end
          cnt_r <= cnt_r + CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  // Registered outputs; HI/LO only change when a result completes, so a zero divisor leaves them intact.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      hi_r   <= {WIDTH{1'b0}};
      lo_r   <= {WIDTH{1'b0}};
      busy_r <= 1'b0;
      done_r <= 1'b0;
      dz_r   <= 1'b0;
    end else begin
      busy_r <= (state_s == S_MULT) || (state_s == S_DIV) || (state_s == S_FIX);
      done_r <= (state_s == S_DONE);
      if (state_r == S_IDLE && (bus.mult_start || bus.div_start)) begin
        dz_r <= ~bus.mult_start & b_zero_s;
      end
      if (state_r == S_MULT && last_s) begin
        hi_r <= prod_hi_s;
        lo_r <= booth_q_s;
      end else if (state_r == S_FIX) begin
        hi_r <= cond_neg(acc_r[WIDTH-1:0], neg_rem_r);
        lo_r <= cond_neg(q_r, neg_q_r);
      end
    end
  end

  assign bus.hi_out   = hi_r;
  assign bus.lo_out   = lo_r;
  assign bus.busy     = busy_r;
  assign bus.done     = done_r;
  assign bus.div_zero = dz_r;

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: vector table plus scoreboard of expected HI/LO results.
module tb_mult_div_unit;

  localparam int W = 32;

  logic clock = 1'b0;
  logic reset = 1'b0;
  int   cyc    = 0;
  int   errors = 0;
  int   checks = 0;

  mult_div_unit_if #(.WIDTH(W)) bus ();

  mult_div_unit #(.WIDTH(W), .CNT_W(6)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dz;
    int           start_cyc;
    int           lat;
  } exp_t;

  typedef struct {
    bit           is_div;
    bit           uns;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    bit           dz;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic start_op(input bit do_mult, input bit do_div, input bit uns,
                          input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] ehi, input logic [W-1:0] elo, input bit edz);
    exp_t e;
    @(negedge clock);
    bus.mult_start = do_mult;
    bus.div_start  = do_div;
    bus.a_in       = a;
    bus.b_in       = b;
`ifdef MULTDIV_UNSIGNED_EN
    bus.is_unsigned = uns;
`endif
    e.hi        = ehi;
    e.lo        = elo;
    e.dz        = edz;
    e.start_cyc = cyc + 1;
    e.lat       = do_mult ? 32 : ((b == 32'd0) ? 0 : 33);
    sb.push_back(e);
    @(posedge clock);
    #1;
    bus.mult_start = 1'b0;
    bus.div_start  = 1'b0;
  endtask

  task automatic wait_done(input int bound, output int busy_cnt);
    bit seen;
    seen     = 1'b0;
    busy_cnt = 0;
    for (int n = 0; n < bound && !seen; n++) begin
      @(negedge clock);
      if (bus.done === 1'b1) seen = 1'b1;
      else if (bus.busy === 1'b1) busy_cnt++;
    end
    check("done_within_bound", 64'(seen), 64'd1);
  endtask

  // Scoreboard: every done must match the oldest outstanding expectation.
  always @(negedge clock) begin
    if (reset && bus.done === 1'b1) begin
      check("done_expected", 64'(sb.size() > 0), 64'd1);
      if (sb.size() > 0) begin
        exp_t e;
        e = sb.pop_front();
        check("hi_out", 64'(bus.hi_out), 64'(e.hi));
        check("lo_out", 64'(bus.lo_out), 64'(e.lo));
        check("div_zero", 64'(bus.div_zero), 64'(e.dz));
        check("latency", 64'(cyc - e.start_cyc), 64'(e.lat));
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int bc;
    bus.mult_start = 1'b0;
    bus.div_start  = 1'b0;
    bus.a_in       = 32'd0;
    bus.b_in       = 32'd0;
`ifdef MULTDIV_UNSIGNED_EN
    bus.is_unsigned = 1'b0;
`endif

    vecs.push_back('{1'b0, 1'b0, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 32'd5,        32'd5,        32'h00000000, 32'h00000019, 1'b0});
    vecs.push_back('{1'b1, 1'b0, 32'd17,       32'hFFFFFFFB, 32'h00000002, 32'hFFFFFFFD, 1'b0});
    vecs.push_back('{1'b1, 1'b0, 32'hFFFFFFEF, 32'd5,        32'hFFFFFFFE, 32'hFFFFFFFD, 1'b0});
    vecs.push_back('{1'b1, 1'b0, 32'h00003412, 32'h00000100, 32'h00000012, 32'h00000034, 1'b0});
    vecs.push_back('{1'b1, 1'b0, 32'h00001234, 32'h00000000, 32'h00000012, 32'h00000034, 1'b1});
    vecs.push_back('{1'b1, 1'b0, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 32'h12345678, 32'h00000010, 32'h00000001, 32'h23456780, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 32'hFFFFFFFF, 32'h7FFFFFFF, 32'hFFFFFFFF, 32'h80000001, 1'b0});
    vecs.push_back('{1'b1, 1'b0, 32'hFFFFFFF9, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'h00000003, 1'b0});
    vecs.push_back('{1'b1, 1'b0, 32'd5,        32'd9,        32'h00000005, 32'h00000000, 1'b0});
`ifdef MULTDIV_UNSIGNED_EN
    vecs.push_back('{1'b0, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0});
    vecs.push_back('{1'b1, 1'b1, 32'hFFFFFFFF, 32'h00000002, 32'h00000001, 32'h7FFFFFFF, 1'b0});
`endif

    repeat (3) @(negedge clock);
    check("reset_hi", 64'(bus.hi_out), 64'd0);
    check("reset_lo", 64'(bus.lo_out), 64'd0);
    check("reset_busy", 64'(bus.busy), 64'd0);
    check("reset_done", 64'(bus.done), 64'd0);
    check("reset_div_zero", 64'(bus.div_zero), 64'd0);
    reset = 1'b1;

    // Table-driven operations, each started the cycle after the previous done.
    foreach (vecs[i]) begin
      start_op(!vecs[i].is_div, vecs[i].is_div, vecs[i].uns, vecs[i].a, vecs[i].b,
               vecs[i].hi, vecs[i].lo, vecs[i].dz);
      wait_done(60, bc);
      check($sformatf("busy_cycles[%0d]", i), 64'(bc),
            64'(!vecs[i].is_div ? 32 : ((vecs[i].b == 32'd0) ? 0 : 33)));
    end

    // Both starts together: multiply wins.
    start_op(1'b1, 1'b1, 1'b0, 32'd6, 32'd7, 32'd0, 32'd42, 1'b0);
    wait_done(60, bc);
    check("both_start_busy", 64'(bc), 64'd32);

    // Starts and operand changes while busy are ignored.
    start_op(1'b1, 1'b0, 1'b0, 32'd3, 32'd4, 32'd0, 32'd12, 1'b0);
    repeat (3) @(negedge clock);
    bus.mult_start = 1'b1;
    bus.div_start  = 1'b1;
    bus.a_in       = $urandom;
    bus.b_in       = 32'd0;
    @(negedge clock);
    bus.mult_start = 1'b0;
    bus.div_start  = 1'b0;
    bus.a_in       = $urandom;
    bus.b_in       = $urandom;
    wait_done(60, bc);

    // Asynchronous reset aborts a multiply with no done.
    start_op(1'b1, 1'b0, 1'b0, 32'd9, 32'd9, 32'd0, 32'd81, 1'b0);
    repeat (10) @(negedge clock);
    #2;
    reset = 1'b0;
    #1;
    check("abort_hi", 64'(bus.hi_out), 64'd0);
    check("abort_lo", 64'(bus.lo_out), 64'd0);
    check("abort_busy", 64'(bus.busy), 64'd0);
    check("abort_done", 64'(bus.done), 64'd0);
    check("abort_div_zero", 64'(bus.div_zero), 64'd0);
    sb.delete();
    @(negedge clock);
    reset = 1'b1;
    repeat (40) @(negedge clock);
    check("idle_after_abort", 64'(bus.busy), 64'd0);

    // Next start after the abort runs normally; results then hold while idle.
    start_op(1'b0, 1'b1, 1'b0, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0);
    wait_done(60, bc);
    check("div_after_abort_busy", 64'(bc), 64'd33);
    repeat (5) @(negedge clock);
    check("hold_hi", 64'(bus.hi_out), 64'd2);
    check("hold_lo", 64'(bus.lo_out), 64'd14);
    check("sb_drained", 64'(sb.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
Multicycle signed multiply/divide unit that produces the HI/LO values for the CPU datapath.
- Sits directly upstream of the HI/LO select muxes and the HI/LO registers.
- Launched by the control FSM for mult/div instructions, with operands taken from registers A and B.
- The control FSM waits on done before asserting WriteHI/WriteLO.

Parameters:
- WIDTH, 32, operand width; hi_out/lo_out are each WIDTH bits.
- CNT_W, 6, iteration-counter width; must hold the value WIDTH.

Ports:
- clock  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset
- mult_start  input  1  one-cycle pulse; starts a multiply of a_in*b_in
- div_start  input  1  one-cycle pulse; starts a divide of a_in/b_in
- a_in  input  WIDTH  multiplicand / dividend (register A)
- b_in  input  WIDTH  multiplier / divisor (register B)
- hi_out  output  WIDTH  mult: product[63:32]; div: remainder
- lo_out  output  WIDTH  mult: product[31:0]; div: quotient
- busy  output  1  high while an operation is in progress
- done  output  1  one-cycle pulse when results are final
- div_zero  output  1  high with done when the divisor was zero

Behaviour:
- Reset (reset=0, any time, asynchronous):
  - state=IDLE.
  - hi_out, lo_out, busy, done, div_zero all =0.
  - Any operation in progress is aborted; no done is issued.
- States: IDLE, MULT, DIV, FIX, DONE.
- IDLE:
  - mult_start=1 -> MULT. Operands are latched and the counter is cleared.
  - div_start=1 -> DIV, or straight to DONE if b_in==0.
  - mult_start and div_start both =1: mult has priority; div_start is ignored.
- Start pulses in any state other than IDLE are ignored. Operands are sampled only at the start edge; later changes to a_in/b_in have no effect.
- MULT:
  - Radix-2 Booth algorithm, one iteration per cycle, WIDTH iterations, then -> DONE.
  - Result is the full 2*WIDTH signed product.
- DIV:
  - Restoring division on operand magnitudes, one quotient bit per cycle, WIDTH iterations, then -> FIX.
- FIX (1 cycle) applies sign correction:
  - Quotient is negated if the operand signs differ (truncation toward zero).
  - Remainder takes the sign of the dividend.
- DONE (1 cycle):
  - done=1; hi_out/lo_out are updated in this cycle; returns to IDLE.
  - hi_out/lo_out hold their value until the next successful completion.
- busy=1 in MULT, DIV and FIX; busy=0 in IDLE and DONE.
- Latency, counting from the edge that samples start:
  - mult: done is high in the cycle after edge +32 (33 cycles).
  - div: done after 34 cycles.
  - divide by zero: done in the next cycle.
- A new start may be accepted in the cycle after done, i.e. back-to-back operations are allowed.
- Divide by zero: div_zero=1 together with done; hi_out/lo_out are left unchanged. div_zero clears on the next start.
- Overflow case: -2^31 / -1 gives lo=0x80000000 and hi=0 (wraps); no flag is raised.
- Multiply never overflows the 64-bit result.

Optional Feature:
MULTDIV_UNSIGNED_EN
- Defined:
  - Adds input port is_unsigned (1 bit), sampled together with the start pulse.
  - When is_unsigned=1, operands are zero-extended, no sign correction is applied, and the Booth sign bit is treated as 0.
  - This implements multu/divu. Latency is unchanged; FIX still occupies its cycle for div.
- Not defined: the port is absent and all operations are signed.

Test Plan:
- mult_start, a=7, b=0xFFFFFFFD (-3) -> done 33 cycles later; hi=0xFFFFFFFF, lo=0xFFFFFFEB; busy high for 32 cycles.
- mult_start, a=b=0x80000000 -> hi=0x40000000, lo=0x00000000. Immediately followed by a second mult 5*5 -> hi=0, lo=0x19.
- div_start, a=17, b=-5 -> lo=0xFFFFFFFD, hi=0x00000002. Then a=-17, b=5 -> lo=0xFFFFFFFD, hi=0xFFFFFFFE. Each done 34 cycles after start.
- Previous hi/lo=0x12/0x34, then div_start with b=0 -> next cycle done=1, div_zero=1, hi/lo stay 0x12/0x34. Then div 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0, div_zero=0.
- mult_start and div_start asserted together -> multiply executes. reset=0 pulsed 10 cycles into a mult -> all outputs 0 immediately, no done ever issued, next start accepted normally.
- With MULTDIV_UNSIGNED_EN:
  - is_unsigned=1, mult 0xFFFFFFFF*0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
  - is_unsigned=1, div 0xFFFFFFFF/2 -> lo=0x7FFFFFFF, hi=1.
